// File: rtl/reg_file_rd2_wr1.sv
// rtl/reg_file_rd2_wr1.sv - 2-read/1-write register file, x0 hardwired to zero, write bypass, registered debug port
module reg_file_rd2_wr1 #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            dbg_valid
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] dbg_data_q;
  logic [XLEN-1:0] dbg_data_d;
  logic            dbg_valid_q;
  logic            dbg_valid_d;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
    // Entry 0 never holds anything but zero, whatever was addressed above.
    regs_d[0]   = '0;
    dbg_data_d  = regs_q[dbg_addr];
    dbg_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  // Writeback bypass lets an instruction read a value retiring in the same cycle.
  assign rs1_data = (!rst || (rs1_addr == '0)) ? '0 :
                    (wr_en && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
  assign rs2_data = (!rst || (rs2_addr == '0)) ? '0 :
                    (wr_en && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];

  assign dbg_data  = dbg_data_q;
  assign dbg_valid = dbg_valid_q;

endmodule

// File: tb/tb_reg_file_rd2_wr1.sv
// tb/tb_reg_file_rd2_wr1.sv - scoreboard bench for reg_file_rd2_wr1 with a behavioural model
module tb_reg_file_rd2_wr1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, dbg_addr;
  logic [31:0] rs1_data, rs2_data, wr_data, dbg_data;
  logic        wr_en;
  logic        dbg_valid;

  reg_file_rd2_wr1 #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_valid(dbg_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
  } exp_t;

  exp_t        rs_q[$];
  exp_t        dbg_q[$];
  logic [31:0] model [32];
  int          cyc    = 0;
  int          passed = 0;
  int          total  = 0;
  bit          done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic we,
      input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] a);
    if (!r || a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = da;
    e.cyc = cyc;
    e.a = model_read(r, we, wa, wd, a1);
    e.b = model_read(r, we, wa, wd, a2);
    e.v = 1'b0;
    rs_q.push_back(e);
    e.a = r ? model[da] : 32'h0;
    e.b = 32'h0;
    e.v = r;
    dbg_q.push_back(e);
    if (!r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    cyc++;
  endtask

  // Monitor: combinational reads checked mid-cycle, debug results one edge later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (rs_q.size() > 0) begin
        e = rs_q.pop_front();
        check("rs1_data", rs1_data, e.a);
        check("rs2_data", rs2_data, e.b);
      end
      while (dbg_q.size() > 0 && dbg_q[0].cyc < cyc - 1) begin
        e = dbg_q.pop_front();
        check("dbg_data", dbg_data, e.a);
        check("dbg_valid", {31'h0, dbg_valid}, {31'h0, e.v});
      end
    end
  end

  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    logic [4:0] wa, a1, a2, da;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;

    // Reset, then sweep every address on both ports and the debug port.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd0);
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));

    // Plain write then read on both ports.
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);

    // Write to x0 is dropped, both during and after the write cycle.
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Bypass on rs1 while rs2 reads an untouched register.
    drive(1'b1, 1'b1, 5'd8, 32'h0BADF00D, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd8, 5'd7);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);

    // Debug port shows pre-write value; overwrite appears two edges later.
    drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd3, 32'h00000001, 5'd3, 5'd0, 5'd3);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);

    // Fill, reset with a write held through it, then read back zeros.
    for (int i = 1; i < 32; i++)
      drive(1'b1, 1'b1, 5'(i), 32'h100 + i, 5'(i), 5'(i - 1), 5'(i));
    drive(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9, 5'd9);
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i ^ 5'h1f), 5'(i));
    drive(1'b1, 1'b1, 5'd9, 32'h00000099, 5'd9, 5'd9, 5'd9);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

    // Random traffic; small address windows make bypass and collisions common.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        wa = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
        a2 = 5'($urandom_range(0, 7)); da = 5'($urandom_range(0, 7));
      end else begin
        wa = 5'($urandom); a1 = 5'($urandom); a2 = 5'($urandom); da = 5'($urandom);
      end
      drive(($urandom_range(0, 39) != 0), 1'($urandom), wa, $urandom, a1, a2, da);
    end

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    #4;
    done = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
